// File: rtl/lc3_datapath_mem.sv
// LC-3 datapath (IR, PC, register file, ALU, address adder, CC, BEN, MAR/MDR)
// with a request/acknowledge memory port, a watchdog timeout and a sticky error flag.
module lc3_datapath_mem #(
  parameter int          WIDTH    = 16,
  parameter logic [15:0] PC_RESET = 16'h3000,
  parameter int          TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] busIn,
  input  logic             LDIR, LDPC, LDREG, LDCC, LDBEN, LDMAR, LDMDR,
  input  logic             MIO_EN,
  input  logic             R_W,
  input  logic [1:0]       PCMUX,
  input  logic [1:0]       DRMUX,
  input  logic [1:0]       SR1MUX,
  input  logic             ADDR1MUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic             MARMUX,
  input  logic [1:0]       ALUK,
  input  logic             GatePC, GateALU, GateMARMUX, GateMDR,
  output logic [WIDTH-1:0] busOut,
  output logic [WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0] memWdata,
  input  logic [WIDTH-1:0] memRdata,
  output logic             memReq,
  output logic             memWe,
  input  logic             memAck,
  output logic             R,
  output logic             memErr,
  output logic [4:0]       IR_15_To_11,
  output logic             BEN,
  output logic [2:0]       NZP
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  logic [WIDTH-1:0] ir, pc, mar, mdr;
  logic [WIDTH-1:0] regs [8];
  logic [2:0]       nzp;
  logic             ben, err, we_q;
  logic [CW-1:0]    cnt;
  state_t           state, state_nxt;

  logic [2:0]       dr, sr1;
  logic [WIDTH-1:0] sr1_out, sr2_out, alu_b, alu_out;
  logic [WIDTH-1:0] addr1, addr2, adder, marmux_out, pc_nxt;

  always_comb begin
    dr  = ir[11:9];
    sr1 = ir[11:9];
    case (DRMUX)
      2'd0:    dr = ir[11:9];
      2'd2:    dr = 3'd6;
      default: dr = 3'd7;
    endcase
    case (SR1MUX)
      2'd0:    sr1 = ir[11:9];
      2'd1:    sr1 = ir[8:6];
      default: sr1 = 3'd6;
    endcase
  end

  // Reads see the pre-write value; no write-through bypass.
  assign sr1_out = regs[sr1];
  assign sr2_out = regs[ir[2:0]];
  assign alu_b   = ir[5] ? {{(WIDTH-5){ir[4]}}, ir[4:0]} : sr2_out;

  always_comb begin
    alu_out = sr1_out;
    case (ALUK)
      2'd0:    alu_out = sr1_out + alu_b;
      2'd1:    alu_out = sr1_out & alu_b;
      2'd2:    alu_out = ~sr1_out;
      default: alu_out = sr1_out;
    endcase
  end

  assign addr1 = ADDR1MUX ? sr1_out : pc;

  always_comb begin
    addr2 = '0;
    case (ADDR2MUX)
      2'd0:    addr2 = '0;
      2'd1:    addr2 = {{(WIDTH-6){ir[5]}},  ir[5:0]};
      2'd2:    addr2 = {{(WIDTH-9){ir[8]}},  ir[8:0]};
      default: addr2 = {{(WIDTH-11){ir[10]}}, ir[10:0]};
    endcase
  end

  assign adder      = addr1 + addr2;
  assign marmux_out = MARMUX ? adder : {{(WIDTH-8){1'b0}}, ir[7:0]};

  always_comb begin
    pc_nxt = pc;
    case (PCMUX)
      2'd0:    pc_nxt = pc + 1'b1;
      2'd1:    pc_nxt = busIn;
      2'd2:    pc_nxt = adder;
      default: pc_nxt = pc;
    endcase
  end

  // Fixed gate priority keeps the bus deterministic if the controller overlaps gates.
  always_comb begin
    busOut = '0;
    if (GatePC)          busOut = pc;
    else if (GateALU)    busOut = alu_out;
    else if (GateMARMUX) busOut = marmux_out;
    else if (GateMDR)    busOut = mdr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir  <= '0;
      pc  <= WIDTH'(PC_RESET);
      nzp <= 3'b010;
      ben <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (LDIR)  ir <= busIn;
      if (LDPC)  pc <= pc_nxt;
      if (LDREG) regs[dr] <= busIn;
      if (LDCC)  nzp <= busIn[WIDTH-1] ? 3'b100 : (busIn == '0) ? 3'b010 : 3'b001;
      if (LDBEN) ben <= (ir[11] & nzp[2]) | (ir[10] & nzp[1]) | (ir[9] & nzp[0]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MIO_EN) state_nxt = REQ;
      REQ:     if (memAck || cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // MAR/MDR only move in IDLE so the memory sees stable address/data during REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mar   <= '0;
      mdr   <= '0;
      cnt   <= '0;
      we_q  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        cnt  <= '0;
        we_q <= R_W;
        if (LDMAR) mar <= busIn;
        if (LDMDR) mdr <= busIn;
      end else if (state == REQ) begin
        if (memAck) begin
          if (!we_q) mdr <= memRdata;
        end else if (cnt == CNT_LAST) begin
          err <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign memReq      = (state == REQ);
  assign memWe       = (state == REQ) & we_q;
  assign memAddr     = mar;
  assign memWdata    = mdr;
  assign R           = (state == DONE);
  assign memErr      = err;
  assign IR_15_To_11 = ir[15:11];
  assign BEN         = ben;
  assign NZP         = nzp;
endmodule

// File: tb/tb_lc3_datapath_mem.sv
// Bench for lc3_datapath_mem: random ALU/adder/bus/CC checks against a reference
// model, an ALU vector table, and hand sequences for memory, branch and reset.
module tb_lc3_datapath_mem;
  logic        clk, rst_n;
  logic [15:0] busIn, busOut, memAddr, memWdata, memRdata;
  logic        LDIR, LDPC, LDREG, LDCC, LDBEN, LDMAR, LDMDR, MIO_EN, R_W;
  logic [1:0]  PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK;
  logic        ADDR1MUX, MARMUX, GatePC, GateALU, GateMARMUX, GateMDR;
  logic        memReq, memWe, memAck, R, memErr, BEN;
  logic [4:0]  IR_15_To_11;
  logic [2:0]  NZP;

  lc3_datapath_mem #(.WIDTH(16), .PC_RESET(16'h3000), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .busIn(busIn),
    .LDIR(LDIR), .LDPC(LDPC), .LDREG(LDREG), .LDCC(LDCC), .LDBEN(LDBEN),
    .LDMAR(LDMAR), .LDMDR(LDMDR), .MIO_EN(MIO_EN), .R_W(R_W),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX), .MARMUX(MARMUX), .ALUK(ALUK),
    .GatePC(GatePC), .GateALU(GateALU), .GateMARMUX(GateMARMUX), .GateMDR(GateMDR),
    .busOut(busOut), .memAddr(memAddr), .memWdata(memWdata), .memRdata(memRdata),
    .memReq(memReq), .memWe(memWe), .memAck(memAck), .R(R), .memErr(memErr),
    .IR_15_To_11(IR_15_To_11), .BEN(BEN), .NZP(NZP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  aluk;
    logic [15:0] exp;
  } vec_t;
  vec_t tv [8];

  // reference model state
  logic [15:0] m_ir, m_pc, m_mdr;
  logic [15:0] m_reg [8];
  logic [2:0]  m_nzp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    busIn = '0; memRdata = '0; memAck = 1'b0;
    {LDIR, LDPC, LDREG, LDCC, LDBEN, LDMAR, LDMDR, MIO_EN, R_W} = '0;
    {PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK} = '0;
    {ADDR1MUX, MARMUX, GatePC, GateALU, GateMARMUX, GateMDR} = '0;
  endtask

  function automatic logic [15:0] sx(input logic [15:0] v, input int n);
    logic signed [15:0] t;
    t = v << (16 - n);
    return t >>> (16 - n);
  endfunction

  function automatic logic [2:0] cc(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 0) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] model_bus();
    logic [15:0] a, b, alu, a1, a2, mm;
    int s1;
    s1 = (SR1MUX == 0) ? int'(m_ir[11:9]) : (SR1MUX == 1) ? int'(m_ir[8:6]) : 6;
    a = m_reg[s1];
    b = m_ir[5] ? sx(m_ir, 5) : m_reg[m_ir[2:0]];
    case (ALUK)
      0: alu = a + b;
      1: alu = a & b;
      2: alu = ~a;
      default: alu = a;
    endcase
    a1 = ADDR1MUX ? a : m_pc;
    case (ADDR2MUX)
      0: a2 = 0;
      1: a2 = sx(m_ir, 6);
      2: a2 = sx(m_ir, 9);
      default: a2 = sx(m_ir, 11);
    endcase
    mm = MARMUX ? (a1 + a2) : {8'h00, m_ir[7:0]};
    if (GatePC) return m_pc;
    if (GateALU) return alu;
    if (GateMARMUX) return mm;
    if (GateMDR) return m_mdr;
    return 16'h0;
  endfunction

  task automatic load_ir(input logic [15:0] v);
    clr(); busIn = v; LDIR = 1'b1; tick(); clr();
  endtask

  task automatic write_reg(input logic [1:0] drm, input logic [15:0] v);
    clr(); busIn = v; DRMUX = drm; LDREG = 1'b1; tick(); clr();
  endtask

  task automatic load_pc(input logic [15:0] v);
    clr(); busIn = v; PCMUX = 2'd1; LDPC = 1'b1; tick(); clr();
  endtask

  initial begin
    logic [15:0] v, d;
    logic [1:0]  drm;
    int          dri, nreq;
    logic        seen_r;

    tv[0] = '{16'h1007, 16'h0005, 16'h0007, 2'd0, 16'h000C};
    tv[1] = '{16'h1007, 16'hFFFF, 16'h0002, 2'd0, 16'h0001};
    tv[2] = '{16'h103F, 16'h0000, 16'h1111, 2'd0, 16'hFFFF};
    tv[3] = '{16'h5007, 16'hF0F0, 16'hFF00, 2'd1, 16'hF000};
    tv[4] = '{16'h502F, 16'h1234, 16'hFFFF, 2'd1, 16'h0004};
    tv[5] = '{16'h9007, 16'h00FF, 16'h0000, 2'd2, 16'hFF00};
    tv[6] = '{16'h0000, 16'hABCD, 16'h0000, 2'd3, 16'hABCD};
    tv[7] = '{16'h1030, 16'h0010, 16'h0000, 2'd0, 16'h0000};

    clr();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_bus_idle", busOut, 16'h0);
    chk("rst_nzp", NZP, 3'b010);
    chk("rst_memReq", memReq, 1'b0);
    chk("rst_R", R, 1'b0);
    chk("rst_memErr", memErr, 1'b0);
    chk("rst_BEN", BEN, 1'b0);
    GatePC = 1'b1; #1;
    chk("rst_pc", busOut, 16'h3000);
    clr();

    // randomized datapath vs model
    m_ir = 0; m_mdr = 0; m_nzp = 3'b010;
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    v = 16'($urandom);
    load_pc(v); m_pc = v;
    for (int it = 0; it < 40; it++) begin
      v = 16'($urandom);
      load_ir(v); m_ir = v;
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = 16'h0;
      drm = 2'($urandom_range(0, 3));
      busIn = d; DRMUX = drm; LDREG = 1'b1; LDCC = 1'b1; LDMDR = 1'b1;
      tick(); clr();
      dri = (drm == 0) ? int'(m_ir[11:9]) : (drm == 2) ? 6 : 7;
      m_reg[dri] = d; m_nzp = cc(d); m_mdr = d;
      chk("rnd_nzp", NZP, m_nzp);
      SR1MUX = 2'($urandom_range(0, 3)); ALUK = 2'($urandom_range(0, 3));
      ADDR1MUX = 1'($urandom_range(0, 1)); ADDR2MUX = 2'($urandom_range(0, 3));
      MARMUX = 1'($urandom_range(0, 1));
      {GatePC, GateALU, GateMARMUX, GateMDR} = 4'($urandom_range(0, 15));
      #1;
      chk("rnd_bus", busOut, model_bus());
      clr();
    end

    // ALU vector table using R6 as SR1 and R7 as SR2
    for (int k = 0; k < 8; k++) begin
      load_ir(tv[k].ir);
      write_reg(2'd2, tv[k].a);
      write_reg(2'd1, tv[k].b);
      SR1MUX = 2'd2; ALUK = tv[k].aluk; GateALU = 1'b1; #1;
      chk($sformatf("alu_vec%0d", k), busOut, tv[k].exp);
      clr();
    end

    // ADD R1,R1,#2 with result looped back
    load_ir(16'h1260);
    write_reg(2'd0, 16'h0005);
    load_ir(16'h1262);
    SR1MUX = 2'd1; ALUK = 2'd0; GateALU = 1'b1; #1;
    chk("add_imm_bus", busOut, 16'h0007);
    busIn = busOut; DRMUX = 2'd0; LDREG = 1'b1; LDCC = 1'b1;
    tick(); clr();
    chk("add_imm_nzp", NZP, 3'b001);
    SR1MUX = 2'd1; ALUK = 2'd3; GateALU = 1'b1; #1;
    chk("add_imm_r1", busOut, 16'h0007);
    clr();

    // read access, ack in third REQ cycle
    busIn = 16'h4000; LDMAR = 1'b1; tick(); clr();
    MIO_EN = 1'b1; R_W = 1'b0; tick(); clr(); #1;
    chk("rd_req", memReq, 1'b1);
    chk("rd_addr", memAddr, 16'h4000);
    chk("rd_we", memWe, 1'b0);
    chk("rd_R_early", R, 1'b0);
    tick();
    busIn = 16'h1111; LDMAR = 1'b1; tick(); clr(); #1;
    chk("rd_mar_locked", memAddr, 16'h4000);
    chk("rd_req_held", memReq, 1'b1);
    memAck = 1'b1; memRdata = 16'hBEEF; tick(); clr();
    MIO_EN = 1'b1; #1;
    chk("rd_R_pulse", R, 1'b1);
    chk("rd_req_drop", memReq, 1'b0);
    tick(); clr(); #1;
    chk("rd_R_one", R, 1'b0);
    chk("rd_no_restart", memReq, 1'b0);
    GateMDR = 1'b1; #1;
    chk("rd_mdr", busOut, 16'hBEEF);
    clr();
    memAck = 1'b1; memRdata = 16'h0000; tick(); clr(); #1;
    GateMDR = 1'b1; #1;
    chk("ack_idle_ignored", busOut, 16'hBEEF);
    chk("ack_idle_noR", R, 1'b0);
    clr();

    // write access with no ack: watchdog
    busIn = 16'h1234; LDMDR = 1'b1; tick(); clr();
    MIO_EN = 1'b1; R_W = 1'b1; tick(); clr(); #1;
    chk("to_we", memWe, 1'b1);
    chk("to_wdata", memWdata, 16'h1234);
    nreq = 0; seen_r = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (memReq) nreq++;
      if (R) begin seen_r = 1'b1; break; end
      tick();
    end
    chk("to_req_cycles", nreq, 8);
    chk("to_R_seen", seen_r, 1'b1);
    chk("to_err", memErr, 1'b1);
    tick(); tick();
    chk("to_err_sticky", memErr, 1'b1);
    GateMDR = 1'b1; #1;
    chk("to_mdr_kept", busOut, 16'h1234);
    clr();

    // branch
    load_pc(16'h3000);
    busIn = 16'h8000; LDCC = 1'b1; tick(); clr();
    chk("br_nzp", NZP, 3'b100);
    load_ir(16'h0805);
    chk("br_opcode", IR_15_To_11, 5'b00001);
    LDBEN = 1'b1; tick(); clr();
    chk("br_ben_n", BEN, 1'b1);
    PCMUX = 2'd2; ADDR1MUX = 1'b0; ADDR2MUX = 2'd2; LDPC = 1'b1; tick(); clr();
    GatePC = 1'b1; #1;
    chk("br_pc", busOut, 16'h3005);
    clr();
    load_ir(16'h0205);
    LDBEN = 1'b1; tick(); clr();
    chk("br_ben_p", BEN, 1'b0);
    load_ir(16'h09FB);
    PCMUX = 2'd2; ADDR2MUX = 2'd2; LDPC = 1'b1; tick(); clr();
    GatePC = 1'b1; #1;
    chk("br_pc_neg", busOut, 16'h3000);
    clr();

    // PC wrap and bus priority
    load_pc(16'hFFFF);
    PCMUX = 2'd0; LDPC = 1'b1; tick(); clr();
    GatePC = 1'b1; #1;
    chk("pc_wrap", busOut, 16'h0000);
    clr();
    load_pc(16'h1234);
    write_reg(2'd2, 16'h5555);
    SR1MUX = 2'd2; ALUK = 2'd3; GatePC = 1'b1; GateALU = 1'b1; #1;
    chk("prio_pc_alu", busOut, 16'h1234);
    GatePC = 1'b0; GateMARMUX = 1'b1; #1;
    chk("prio_alu_mar", busOut, 16'h5555);
    GateALU = 1'b0; GateMDR = 1'b1; MARMUX = 1'b0; #1;
    chk("prio_mar_mdr", busOut, 16'h00FB);
    clr();
    chk("err_still_set", memErr, 1'b1);

    // reset in the middle of a read
    busIn = 16'h0042; LDMAR = 1'b1; tick(); clr();
    MIO_EN = 1'b1; tick(); clr();
    chk("mid_req", memReq, 1'b1);
    #3 rst_n = 1'b0; memAck = 1'b1; memRdata = 16'hDEAD;
    #1;
    chk("mid_req_async", memReq, 1'b0);
    chk("mid_err_clr", memErr, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; clr(); #1;
    GateMDR = 1'b1; #1;
    chk("mid_mdr", busOut, 16'h0000);
    clr();
    GatePC = 1'b1; #1;
    chk("mid_pc", busOut, 16'h3000);
    clr();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/lc3_datapath_mem.md
Name: lc3_datapath_mem

Overview:
- Parametrised next-generation LC-3 datapath. Contains IR, PC, register file, ALU, address adder, condition codes, BEN, MAR/MDR and one shared bus output.
- Adds a request/acknowledge memory port driven by an internal FSM, with a watchdog timeout and a sticky error flag.
- Controlled cycle-by-cycle by the external LC-3 control unit; the memory-ready flag R is returned to it.

Parameters:
- WIDTH, 16, datapath/register/bus width; must be >=16; instruction fields decode from IR[15:0].
- PC_RESET, 16'h3000, PC value after reset (zero-extended to WIDTH).
- TIMEOUT, 64, max cycles in REQ waiting for memAck; must be >=2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- busIn  in  WIDTH  shared bus value, source of all bus loads
- LDIR, LDPC, LDREG, LDCC, LDBEN, LDMAR, LDMDR  in  1 each  register load enables
- MIO_EN  in  1  start memory access
- R_W  in  1  1=write, 0=read
- PCMUX  in  2  0:PC+1, 1:busIn, 2:adder, 3:hold
- DRMUX  in  2  0:IR[11:9], 1:R7, 2:R6, 3:R7
- SR1MUX  in  2  0:IR[11:9], 1:IR[8:6], 2:R6, 3:R6
- ADDR1MUX  in  1  0:PC, 1:SR1OUT
- ADDR2MUX  in  2  0:zero, 1:sext(IR[5:0]), 2:sext(IR[8:0]), 3:sext(IR[10:0])
- MARMUX  in  1  0:zext(IR[7:0]), 1:adder
- ALUK  in  2  0:ADD, 1:AND, 2:NOT A, 3:PASS A
- GatePC, GateALU, GateMARMUX, GateMDR  in  1 each  bus drive selects
- busOut  out  WIDTH  datapath bus contribution
- memAddr  out  WIDTH  memory address
- memWdata  out  WIDTH  memory write data
- memRdata  in  WIDTH  memory read data
- memReq  out  1  request, held high in REQ
- memWe  out  1  write qualifier, valid while memReq
- memAck  in  1  memory completion
- R  out  1  one-cycle memory-done pulse to controller
- memErr  out  1  sticky timeout flag
- IR_15_To_11  out  5  opcode plus IR[11] to controller
- BEN  out  1  registered branch enable
- NZP  out  3  condition codes

Behaviour:
- Reset (async, rst_n=0):
  - IR=0, PC=PC_RESET, R0..R7=0, MAR=0, MDR=0.
  - NZP=3'b010, BEN=0, memErr=0, FSM=IDLE, memReq=0, R=0.
- All loads occur on the rising clk edge when the enable is high.
- Register file: 2 combinational reads (SR1 via SR1MUX, SR2=IR[2:0]) and 1 write (DR via DRMUX, data busIn, on LDREG). A read in the write cycle returns the old value; there is no bypass.
- ALU:
  - B operand = IR[5] ? sext(IR[4:0]) : SR2OUT.
  - Arithmetic is modulo 2^WIDTH; carry is dropped.
- Adder = ADDR1 + ADDR2, modulo 2^WIDTH.
- PC: loads on LDPC per PCMUX. PC+1 wraps from all-ones to 0.
- CC: on LDCC from busIn. N = busIn[WIDTH-1]; Z = busIn==0; P = otherwise. Exactly one bit is ever set.
- BEN: on LDBEN, BEN <= (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), using the current NZP.
- busOut:
  - Fixed priority PC > ALU > MARMUX > MDR.
  - 0 when no gate is high.
  - Multiple gates are a controller error but remain deterministic.
- MAR/MDR: LDMAR and LDMDR take effect only in IDLE; they are ignored in REQ/DONE.
- Memory FSM:
  - IDLE: when MIO_EN=1, enter REQ and clear the timeout counter.
  - REQ: memReq=1, memAddr=MAR, memWe=R_W, memWdata=MDR, all stable for the whole state.
    - memAck=1: if read, MDR<=memRdata; go to DONE.
    - Else count up. If the counter reaches TIMEOUT-1 with no ack: memErr<=1, MDR unchanged, go to DONE.
  - DONE: R=1 for exactly this cycle, memReq=0, then go to IDLE. MIO_EN in DONE does not start a new access.
  - Access latency: at least 2 cycles from MIO_EN to the R pulse (ack in the first REQ cycle gives R in the following cycle).
- memAck outside REQ is ignored.
- memErr clears only on reset.
- Reset mid-access: memReq drops immediately (async) and no MDR update occurs.

Test Plan:
- Reset: hold rst_n=0, release -> PC=16'h3000, NZP=010, busOut=0, memReq=0, R=0, memErr=0.
- ADD immediate:
  - Stimulus: R1=5 via busIn/LDREG/DRMUX=0 with IR=16'h1260 (ADD R1,R1,#0, DR=1). Then IR=16'h1262 (ADD R1,R1,#2), GateALU=1, busIn looped to LDREG/LDCC.
  - Response: R1=7, NZP=001.
- Read access:
  - Stimulus: MAR=16'h4000, MIO_EN=1, R_W=0, memAck asserted 3 cycles after memReq with memRdata=16'hBEEF.
  - Response: memAddr=4000 held throughout, MDR=BEEF, R high for one cycle after ack, GateMDR drives BEEF.
- Timeout: with TIMEOUT=8, issue a write and never ack -> memReq high 8 cycles, then memErr=1, R pulse, MDR unchanged; memErr stays 1 until rst_n.
- Branch:
  - Stimulus: LDCC with busIn=16'h8000 (NZP=100). IR=16'h0805 (BRn +5), LDBEN.
  - Response: BEN=1. PCMUX=2, ADDR2MUX=2, LDPC -> PC=old PC+5.
  - Repeat with IR=16'h0205 (BRp) -> BEN=0.
- PC wrap / priority: PC=16'hFFFF, PCMUX=0, LDPC -> PC=0. Then GatePC and GateALU both high -> busOut=PC.
